// File: rtl/cmp8_arb_ctrl.sv
// cmp8_arb_ctrl: shares one external 8-bit comparator among four requesters.
// Define CMP_ARB_FIXED_PRIO_EN for fixed priority instead of round-robin.
module cmp8_arb_ctrl #(
  parameter int unsigned SETTLE = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [31:0] a_bus,
  input  logic [31:0] b_bus,
  output logic [3:0]  grant,
  output logic        done,
  output logic        eq,
  output logic        gt,
  output logic        busy,
  output logic [7:0]  cmp_p,
  output logic [7:0]  cmp_q,
  input  logic        cmp_eq_n,
  input  logic        cmp_gt_n
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [3:0]  cnt;
  logic [3:0]  cnt_nx;
  logic [3:0]  grant_nx;
  logic [7:0]  p_nx;
  logic [7:0]  q_nx;
  logic        eq_nx;
  logic        gt_nx;
  logic [1:0]  win;
  logic        keep;

  // the granted requester still wants the comparator
  assign keep = |(req & grant);
  assign done = (state == ST_DONE);
  assign busy = (state != ST_IDLE);

`ifdef CMP_ARB_FIXED_PRIO_EN
  // lowest-numbered active requester wins
  always_comb begin
    win = 2'd0;
    for (int i = 3; i >= 0; i--)
      if (req[i]) win = 2'(i);
  end
`else
  logic [1:0] last_grant;
  logic [1:0] idx;

  // nearest active requester above the previous winner wins
  always_comb begin
    win = 2'd0;
    idx = 2'd0;
    for (int k = 4; k >= 1; k--) begin
      idx = last_grant + 2'(k);
      if (req[idx]) win = idx;
    end
  end

  // previous winner moves only when a grant is issued
  always_ff @(posedge clk) begin
    if (rst)
      last_grant <= 2'd3;
    else if (state == ST_IDLE && |req)
      last_grant <= win;
  end
`endif

  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      grant <= 4'd0;
      cnt   <= 4'd0;
      cmp_p <= 8'd0;
      cmp_q <= 8'd0;
      eq    <= 1'b0;
      gt    <= 1'b0;
    end else begin
      state <= state_nx;
      grant <= grant_nx;
      cnt   <= cnt_nx;
      cmp_p <= p_nx;
      cmp_q <= q_nx;
      eq    <= eq_nx;
      gt    <= gt_nx;
    end
  end

  // next-state and next-register values
  always_comb begin
    state_nx = state;
    grant_nx = grant;
    cnt_nx   = cnt;
    p_nx     = cmp_p;
    q_nx     = cmp_q;
    eq_nx    = eq;
    gt_nx    = gt;
    unique case (state)
      ST_IDLE: begin
        grant_nx = 4'd0;
        if (|req) begin
          grant_nx = 4'b0001 << win;
          p_nx     = a_bus[{win, 3'b000} +: 8];
          q_nx     = b_bus[{win, 3'b000} +: 8];
          cnt_nx   = 4'(SETTLE - 1);
          state_nx = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (!keep) begin
          grant_nx = 4'd0;
          state_nx = ST_IDLE;
        end else if (cnt == 4'd0) begin
          state_nx = ST_SAMPLE;
        end else begin
          cnt_nx = cnt - 4'd1;
        end
      end
      ST_SAMPLE: begin
        if (!keep) begin
          grant_nx = 4'd0;
          state_nx = ST_IDLE;
        end else begin
          eq_nx    = ~cmp_eq_n;
          gt_nx    = ~cmp_gt_n;
          state_nx = ST_DONE;
        end
      end
      ST_DONE: begin
        grant_nx = 4'd0;
        state_nx = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cmp8_arb_ctrl.sv
// tb_cmp8_arb_ctrl: randomized checks of cmp8_arb_ctrl against a
// transaction-level model of arbitration, latency and results.
module tb_cmp8_arb_ctrl;

  localparam int ST = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] a_bus, b_bus;
  logic [3:0]  grant;
  logic        done, eq, gt, busy;
  logic [7:0]  cmp_p, cmp_q;
  logic        cmp_eq_n, cmp_gt_n;

  logic [3:0]  req1;
  logic [31:0] a1, b1;
  logic [3:0]  grant1;
  logic        done1, eq1, gt1, busy1;
  logic [7:0]  p1, q1;
  logic        eqn1, gtn1;

  int   total = 0;
  int   bad = 0;
  int   last_m = 3;
  logic eq_m = 1'b0;
  logic gt_m = 1'b0;
  logic [3:0] op_grant;

  always #5 clk = ~clk;

  assign cmp_eq_n = ~(cmp_p == cmp_q);
  assign cmp_gt_n = ~(cmp_p > cmp_q);
  assign eqn1 = ~(p1 == q1);
  assign gtn1 = ~(p1 > q1);

  cmp8_arb_ctrl #(.SETTLE(ST)) dut (
    .clk(clk), .rst(rst), .req(req),
    .a_bus(a_bus), .b_bus(b_bus),
    .grant(grant), .done(done), .eq(eq), .gt(gt), .busy(busy),
    .cmp_p(cmp_p), .cmp_q(cmp_q),
    .cmp_eq_n(cmp_eq_n), .cmp_gt_n(cmp_gt_n)
  );

  cmp8_arb_ctrl #(.SETTLE(1)) dut1 (
    .clk(clk), .rst(rst), .req(req1),
    .a_bus(a1), .b_bus(b1),
    .grant(grant1), .done(done1), .eq(eq1), .gt(gt1), .busy(busy1),
    .cmp_p(p1), .cmp_q(q1),
    .cmp_eq_n(eqn1), .cmp_gt_n(gtn1)
  );

  function automatic int pick(input logic [3:0] r);
`ifdef CMP_ARB_FIXED_PRIO_EN
    for (int i = 0; i < 4; i++)
      if (r[i]) return i;
`else
    for (int k = 1; k <= 4; k++)
      if (r[(last_m + k) % 4]) return (last_m + k) % 4;
`endif
    return 0;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [3:0] r, input logic [7:0] pa,
                       input logic [7:0] pb);
    int w;
    int n;
    logic [3:0] eg;
    w = pick(r);
    eg = 4'b0001 << w;
    a_bus = $urandom;
    b_bus = $urandom;
    a_bus[8*w +: 8] = pa;
    b_bus[8*w +: 8] = pb;
    req = r;
    tick;
    last_m = w;
    op_grant = grant;
    total++;
    if (grant !== eg) begin
      bad++;
      $display("FAIL op_grant got=%b exp=%b", grant, eg);
    end
    total++;
    if (cmp_p !== pa || cmp_q !== pb || busy !== 1'b1) begin
      bad++;
      $display("FAIL op_capture got=%h/%h/%b exp=%h/%h/1",
               cmp_p, cmp_q, busy, pa, pb);
    end
    n = 1;
    while (!done && n < 20) begin
      total++;
      if (cmp_p !== pa || cmp_q !== pb || grant !== eg ||
          eq !== eq_m || gt !== gt_m) begin
        bad++;
        $display("FAIL op_hold n=%0d got=%h/%h/%b/%b%b exp=%h/%h/%b/%b%b",
                 n, cmp_p, cmp_q, grant, eq, gt, pa, pb, eg, eq_m, gt_m);
      end
      a_bus = $urandom;
      b_bus = $urandom;
      tick;
      n++;
    end
    eq_m = (pa == pb);
    gt_m = (pa > pb);
    total++;
    if (done !== 1'b1 || n != ST + 2) begin
      bad++;
      $display("FAIL op_latency got=%0d exp=%0d", n, ST + 2);
    end
    total++;
    if (eq !== eq_m || gt !== gt_m || grant !== eg || cmp_p !== pa) begin
      bad++;
      $display("FAIL op_result got=%b%b/%b exp=%b%b/%b",
               eq, gt, grant, eq_m, gt_m, eg);
    end
    tick;
    total++;
    if (done !== 1'b0 || grant !== 4'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL op_idle got=%b/%b/%b exp=0/0000/0", done, grant, busy);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req = 4'd0;
    req1 = 4'd0;
    a_bus = '0; b_bus = '0; a1 = '0; b1 = '0;
    tick;
    tick;
    total++;
    if ({grant, done, eq, gt, busy, cmp_p, cmp_q} !== '0) begin
      bad++;
      $display("FAIL reset got=%b/%b%b%b%b/%h/%h exp=0",
               grant, done, eq, gt, busy, cmp_p, cmp_q);
    end
    rst = 1'b0;
    last_m = 3; eq_m = 1'b0; gt_m = 1'b0;
    tick;
  endtask

  task automatic test_single;
    do_op(4'b0001, 8'h5A, 8'h3C);
    total++;
    if (op_grant !== 4'b0001 || eq !== 1'b0 || gt !== 1'b1) begin
      bad++;
      $display("FAIL single got=%b/%b%b exp=0001/01", op_grant, eq, gt);
    end
    req = 4'd0;
    tick;
  endtask

  task automatic test_equal;
    do_op(4'b0100, 8'h80, 8'h80);
    total++;
    if (op_grant !== 4'b0100 || eq !== 1'b1 || gt !== 1'b0) begin
      bad++;
      $display("FAIL equal got=%b/%b%b exp=0100/10", op_grant, eq, gt);
    end
    do_op(4'b0100, 8'h01, 8'hFF);
    total++;
    if (eq !== 1'b0 || gt !== 1'b0) begin
      bad++;
      $display("FAIL less got=%b%b exp=00", eq, gt);
    end
    req = 4'd0;
    tick;
  endtask

  task automatic test_round_robin;
    logic [3:0] order [5];
`ifdef CMP_ARB_FIXED_PRIO_EN
    order = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
    rst = 1'b1;
    tick;
    rst = 1'b0;
    last_m = 3; eq_m = 1'b0; gt_m = 1'b0;
    for (int i = 0; i < 5; i++) begin
      do_op(4'b1111, 8'($urandom), 8'($urandom));
      total++;
      if (op_grant !== order[i]) begin
        bad++;
        $display("FAIL rr_order i=%0d got=%b exp=%b", i, op_grant, order[i]);
      end
    end
    req = 4'd0;
    tick;
  endtask

  task automatic test_abort;
    last_m = pick(4'b0010);
    req = 4'b0010;
    a_bus = $urandom;
    b_bus = $urandom;
    tick;
    total++;
    if (grant !== 4'b0010) begin
      bad++;
      $display("FAIL abort_grant got=%b exp=0010", grant);
    end
    tick;
    req = 4'd0;
    tick;
    total++;
    if (grant !== 4'd0 || busy !== 1'b0 || done !== 1'b0 ||
        eq !== eq_m || gt !== gt_m) begin
      bad++;
      $display("FAIL abort got=%b/%b/%b/%b%b exp=0000/0/0/%b%b",
               grant, busy, done, eq, gt, eq_m, gt_m);
    end
    tick;
    total++;
    if (done !== 1'b0 || eq !== eq_m || gt !== gt_m) begin
      bad++;
      $display("FAIL abort_after got=%b/%b%b exp=0/%b%b",
               done, eq, gt, eq_m, gt_m);
    end
  endtask

  task automatic test_reset_mid;
    req = 4'b0001;
    a_bus = $urandom;
    b_bus = $urandom;
    tick;
    tick;
    tick;
    total++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      bad++;
      $display("FAIL mid_busy got=%b/%b exp=1/0", busy, done);
    end
    rst = 1'b1;
    tick;
    total++;
    if ({grant, done, eq, gt, busy, cmp_p, cmp_q} !== '0) begin
      bad++;
      $display("FAIL mid_reset got=%b/%b%b%b%b/%h/%h exp=0",
               grant, done, eq, gt, busy, cmp_p, cmp_q);
    end
    rst = 1'b0;
    req = 4'd0;
    last_m = 3; eq_m = 1'b0; gt_m = 1'b0;
    tick;
    do_op(4'b1010, 8'($urandom), 8'($urandom));
    total++;
    if (op_grant !== 4'b0010) begin
      bad++;
      $display("FAIL mid_first got=%b exp=0010", op_grant);
    end
    req = 4'd0;
    tick;
  endtask

  task automatic test_random;
    logic [7:0] pa, pb;
    for (int i = 0; i < 25; i++) begin
      pa = 8'($urandom);
      pb = ($urandom_range(0, 3) == 0) ? pa : 8'($urandom);
      do_op(4'($urandom_range(1, 15)), pa, pb);
      if ($urandom_range(0, 1) == 1) begin
        req = 4'd0;
        tick;
      end
    end
    req = 4'd0;
    tick;
  endtask

  task automatic test_settle1;
    int n;
    req1 = 4'b0001;
    a1 = $urandom;
    b1 = $urandom;
    a1[7:0] = 8'h10;
    b1[7:0] = 8'h20;
    tick;
    total++;
    if (grant1 !== 4'b0001 || p1 !== 8'h10 || q1 !== 8'h20) begin
      bad++;
      $display("FAIL s1_grant got=%b/%h/%h exp=0001/10/20", grant1, p1, q1);
    end
    n = 1;
    while (!done1 && n < 20) begin
      a1 = $urandom;
      tick;
      n++;
    end
    total++;
    if (done1 !== 1'b1 || n != 3 || eq1 !== 1'b0 || gt1 !== 1'b0 ||
        p1 !== 8'h10) begin
      bad++;
      $display("FAIL s1_done got=%0d/%b%b/%h exp=3/00/10", n, eq1, gt1, p1);
    end
    req1 = 4'd0;
    tick;
  endtask

  initial begin
    test_reset;
    test_single;
    test_equal;
    test_round_robin;
    test_abort;
    test_reset_mid;
    test_random;
    test_settle1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cmp8_arb_ctrl.md
CMP8_ARB_CTRL -- requirements
Module: cmp8_arb_ctrl

Interface
REQ-001 Parameter SETTLE, default 2, sets the comparator settle wait in clock cycles; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 req  input  4  per-requester compare request, level, bit i = requester i.
REQ-005 a_bus  input  32  P operands, packed; requester i uses bits [8i+7:8i].
REQ-006 b_bus  input  32  Q operands, packed; requester i uses bits [8i+7:8i].
REQ-007 grant  output  4  one-hot owner of the comparator; all zero when idle.
REQ-008 done  output  1  one-cycle pulse; the result is valid for the granted requester.
REQ-009 eq  output  1  registered result, P==Q, active-high.
REQ-010 gt  output  1  registered result, P>Q unsigned, active-high.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 cmp_p  output  8  P operand driven to the external 8-bit comparator.
REQ-013 cmp_q  output  8  Q operand driven to the external 8-bit comparator.
REQ-014 cmp_eq_n  input  1  comparator P=Q output, active-low.
REQ-015 cmp_gt_n  input  1  comparator P>Q output, active-low.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, SETTLE, SAMPLE and DONE.
REQ-017 IDLE with any req bit set: register the arbitration winner into grant, load cmp_p/cmp_q from the winner's slices, load the settle counter with SETTLE-1, and go to SETTLE.
REQ-018 IDLE with req==0: stay in IDLE, with grant=0 and cmp_p/cmp_q holding their last values.
REQ-019 SETTLE: decrement the counter each cycle and go to SAMPLE in the cycle the counter reads 0, so SETTLE occupies exactly SETTLE cycles.
REQ-020 SAMPLE: register eq=~cmp_eq_n and gt=~cmp_gt_n, then go to DONE.
REQ-021 DONE: assert done for one cycle, clear grant at the end of the cycle, and go to IDLE.
REQ-022 Latency from req sampled in IDLE to done high SHALL be SETTLE+2 cycles (4 cycles at the default).
REQ-023 eq and gt SHALL hold their values until the next SAMPLE; they are never cleared by abort.
REQ-024 cmp_p and cmp_q SHALL remain stable from grant until the end of DONE; they never change mid-operation.
REQ-025 Operands are captured at grant; later changes on a_bus/b_bus SHALL not affect the current operation.
REQ-026 Abort: if req of the granted requester drops in SETTLE or SAMPLE, go to IDLE next cycle with no done, grant cleared, and eq/gt unchanged.
REQ-027 A req drop in DONE is not an abort; done still pulses.
REQ-028 A requester still holding req after DONE is re-arbitrated normally, with no back-to-back priority guarantee.
REQ-029 Round-robin mode: search upward from (last_grant+1) mod 4, wrapping 3->0; last_grant updates only on grant.
REQ-030 New requests arriving while busy SHALL wait; at most one grant bit is ever high.

Reset
REQ-031 With rst high at a clock edge: state=IDLE, grant=0, done=0, eq=0, gt=0, busy=0, cmp_p=0, cmp_q=0, settle counter=0, last_grant=3 (requester 0 wins first).
REQ-032 Reset SHALL override all other events, including mid-operation, with no done emitted.

Configuration
REQ-033 With macro CMP_ARB_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority (req[0] highest, req[3] lowest) and last_grant is not implemented.
REQ-034 Without CMP_ARB_FIXED_PRIO_EN, round-robin per REQ-029 SHALL apply.

Verification
REQ-035 Single compare (SETTLE=2): req=0001, a[7:0]=0x5A, b[7:0]=0x3C -> grant=0001 at +1, cmp_p=0x5A, cmp_q=0x3C, done at +4, eq=0, gt=1.
REQ-036 Equal operands: requester 2 with a=b=0x80 -> grant=0100, done at +4, eq=1, gt=0; then a=0x01, b=0xFF -> eq=0, gt=0.
REQ-037 Round-robin: req=1111 held continuously -> grant order 0001,0010,0100,1000,0001; each done SETTLE+2 cycles after the IDLE sample. With CMP_ARB_FIXED_PRIO_EN -> grant always 0001.
REQ-038 Abort: req=0010, drop req[1] in the second SETTLE cycle -> next cycle IDLE, grant=0, no done, eq/gt keep their prior values.
REQ-039 Reset mid-operation: assert rst in SAMPLE -> next cycle all outputs zero, busy=0; first grant after reset with req=1010 is 0010.
REQ-040 Operand stability: change a_bus during SETTLE -> cmp_p unchanged and result reflects the captured operand; SETTLE=1 -> done at +3.
